mem_wb_stage: RTL

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/fwd_unit.sv | 50 +++++
 rtl/mem_wb_stage.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types for the memory/writeback slice: result select,
// memory FSM state and forwarding select encodings, plus width defaults.
package pipe_pkg;

   localparam int DEF_A_WIDTH = 5;
   localparam int DEF_D_WIDTH = 32;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } result_src_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      WAIT = 2'b10
   } mem_state_t;

   typedef enum logic [1:0] {
      FWD_NONE = 2'b00,
      FWD_W    = 2'b01,
      FWD_M    = 2'b10
   } fwd_sel_t;

endpackage

// File: rtl/fwd_unit.sv
// Forwarding comparators: selects M-stage or W-stage bypass for the two
// EX source operands. M wins over W; loads still in M are never bypassed.
module fwd_unit
   import pipe_pkg::*;
#(
   parameter int A_WIDTH = DEF_A_WIDTH
) (
   input  logic               valid_m,
   input  logic               reg_write_m,
   input  logic [A_WIDTH-1:0] rd_m,
   input  logic [1:0]         result_src_m,
   input  logic               reg_write_w,
   input  logic [A_WIDTH-1:0] rd_w,
   input  logic [A_WIDTH-1:0] rs1_e,
   input  logic [A_WIDTH-1:0] rs2_e,
   output logic [1:0]         forward_a,
   output logic [1:0]         forward_b
);

   logic m_src_ok_s;

   // M can bypass only a committed-to-write, non-load, non-x0 destination.
   always_comb begin
      m_src_ok_s = valid_m && reg_write_m && (rd_m != {A_WIDTH{1'b0}})
                   && (result_src_m != RES_MEM);
   end

   // Operand A select.
   always_comb begin
      if (m_src_ok_s && (rd_m == rs1_e)) begin
         forward_a = FWD_M;
      end else if (reg_write_w && (rd_w == rs1_e)) begin
         forward_a = FWD_W;
      end else begin
         forward_a = FWD_NONE;
      end
   end

   // Operand B select.
   always_comb begin
      if (m_src_ok_s && (rd_m == rs2_e)) begin
         forward_b = FWD_M;
      end else if (reg_write_w && (rd_w == rs2_e)) begin
         forward_b = FWD_W;
      end else begin
         forward_b = FWD_NONE;
      end
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: one M slot with a request/response memory FSM and
// a registered writeback port. Operand forwarding is built only when
// MEMWB_FORWARDING_EN is defined; otherwise the forward selects read 00.
module mem_wb_stage
   import pipe_pkg::*;
#(
   parameter int A_WIDTH = DEF_A_WIDTH,
   parameter int D_WIDTH = DEF_D_WIDTH
) (
   input  logic               CLK,
   input  logic               rst,
   input  logic               ex_valid,
   input  logic [D_WIDTH-1:0] ALUResultE,
   input  logic [D_WIDTH-1:0] WriteDataE,
   input  logic [D_WIDTH-1:0] PCPlus4E,
   input  logic [A_WIDTH-1:0] RdE,
   input  logic [A_WIDTH-1:0] Rs1E,
   input  logic [A_WIDTH-1:0] Rs2E,
   input  logic               RegWriteE,
   input  logic               MemWriteE,
   input  logic               MemReadE,
   input  logic [1:0]         ResultSrcE,
   output logic               ex_ready,
   output logic               mem_req_valid,
   input  logic               mem_req_ready,
   output logic [D_WIDTH-1:0] mem_addr,
   output logic [D_WIDTH-1:0] mem_wdata,
   output logic               mem_we,
   input  logic               mem_rsp_valid,
   input  logic [D_WIDTH-1:0] mem_rsp_data,
   output logic [D_WIDTH-1:0] ResultW,
   output logic [A_WIDTH-1:0] RdW,
   output logic               RegWriteW,
   output logic [1:0]         ForwardAE,
   output logic [1:0]         ForwardBE,
   output logic [D_WIDTH-1:0] ALUResultM
);

   mem_state_t         state_r;
   logic               valid_m_r;
   logic               req_valid_r;
   logic [D_WIDTH-1:0] alu_m_r;
   logic [D_WIDTH-1:0] wdata_m_r;
   logic [D_WIDTH-1:0] pc4_m_r;
   logic [A_WIDTH-1:0] rd_m_r;
   logic               reg_write_m_r;
   logic               mem_write_m_r;
   logic               mem_read_m_r;
   logic [1:0]         src_m_r;
   logic [D_WIDTH-1:0] result_w_r;
   logic [A_WIDTH-1:0] rd_w_r;
   logic               reg_write_w_r;
   logic               m_done_s;
   logic               ex_ready_s;
   logic               capture_s;

   // Completion of the op held in M; a load may finish in REQ when the
   // response arrives together with the acceptance.
   always_comb begin
      m_done_s = 1'b0;
      if (valid_m_r) begin
         case (state_r)
            IDLE:    m_done_s = !(mem_read_m_r || mem_write_m_r);
            REQ:     m_done_s = mem_write_m_r ? mem_req_ready
                                              : (mem_req_ready && mem_rsp_valid);
            WAIT:    m_done_s = mem_rsp_valid;
            default: m_done_s = 1'b0;
         endcase
      end else begin
         m_done_s = 1'b0;
      end
   end

   // Slot is free when empty or draining this cycle.
   always_comb begin
      ex_ready_s = !valid_m_r || m_done_s;
      capture_s  = ex_valid && ex_ready_s;
   end

   // M slot capture and memory handshake FSM.
   always_ff @(posedge CLK) begin
      if (rst) begin
         state_r       <= IDLE;
         valid_m_r     <= 1'b0;
         req_valid_r   <= 1'b0;
         alu_m_r       <= {D_WIDTH{1'b0}};
         wdata_m_r     <= {D_WIDTH{1'b0}};
         pc4_m_r       <= {D_WIDTH{1'b0}};
         rd_m_r        <= {A_WIDTH{1'b0}};
         reg_write_m_r <= 1'b0;
         mem_write_m_r <= 1'b0;
         mem_read_m_r  <= 1'b0;
         src_m_r       <= 2'b00;
      end else if (capture_s) begin
         valid_m_r     <= 1'b1;
         alu_m_r       <= ALUResultE;
         wdata_m_r     <= WriteDataE;
         pc4_m_r       <= PCPlus4E;
         rd_m_r        <= RdE;
         reg_write_m_r <= RegWriteE;
         mem_write_m_r <= MemWriteE;
         mem_read_m_r  <= MemReadE;
         src_m_r       <= ResultSrcE;
         if (MemReadE || MemWriteE) begin
            state_r     <= REQ;
            req_valid_r <= 1'b1;
         end else begin
            state_r     <= IDLE;
            req_valid_r <= 1'b0;
         end
      end else if (m_done_s) begin
         valid_m_r   <= 1'b0;
         state_r     <= IDLE;
         req_valid_r <= 1'b0;
      end else begin
         case (state_r)
            REQ: begin
               if (mem_req_ready) begin
                  state_r     <= WAIT;
                  req_valid_r <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Writeback register: one RegWriteW pulse per completed op.
   always_ff @(posedge CLK) begin
      if (rst) begin
         result_w_r    <= {D_WIDTH{1'b0}};
         rd_w_r        <= {A_WIDTH{1'b0}};
         reg_write_w_r <= 1'b0;
      end else begin
         reg_write_w_r <= m_done_s && reg_write_m_r && (rd_m_r != {A_WIDTH{1'b0}});
         if (m_done_s) begin
            rd_w_r <= rd_m_r;
            case (src_m_r)
               RES_MEM: result_w_r <= mem_rsp_data;
               RES_PC4: result_w_r <= pc4_m_r;
               default: result_w_r <= alu_m_r;
            endcase
         end
      end
   end

   assign ex_ready      = ex_ready_s;
   assign mem_req_valid = req_valid_r;
   assign mem_addr      = alu_m_r;
   assign mem_wdata     = wdata_m_r;
   assign mem_we        = mem_write_m_r;
   assign ResultW       = result_w_r;
   assign RdW           = rd_w_r;
   assign RegWriteW     = reg_write_w_r;
   assign ALUResultM    = alu_m_r;

`ifdef MEMWB_FORWARDING_EN
   fwd_unit #(
      .A_WIDTH (A_WIDTH)
   ) u_fwd (
      .valid_m      (valid_m_r),
      .reg_write_m  (reg_write_m_r),
      .rd_m         (rd_m_r),
      .result_src_m (src_m_r),
      .reg_write_w  (reg_write_w_r),
      .rd_w         (rd_w_r),
      .rs1_e        (Rs1E),
      .rs2_e        (Rs2E),
      .forward_a    (ForwardAE),
      .forward_b    (ForwardBE)
   );
`else
   logic unused_fwd_s;
   assign unused_fwd_s = ^{Rs1E, Rs2E};
   assign ForwardAE    = 2'b00;
   assign ForwardBE    = 2'b00;
`endif

endmodule
